// File: rtl/rx_sfd_timestamp.sv
// ---------------------------------------------------------------------------
// rx_sfd_timestamp
//
// Captures the free-running time counter when a received frame's SFD is
// detected. It queues {start timestamp, duration} in a small FIFO when the
// frame completes with an END event.
//
// Build option: define RX_TS_DURATION_EN to compute, store and drive the
// frame duration on o_dur. When the macro is undefined there is no duration
// storage, and o_dur is tied to zero.
//
// Parameters
//   TS_WIDTH      width of the time counter and of the timestamps
//   FIFO_DEPTH    number of timestamp entries (power of two, >= 2)
//   RX_EVENT_END  RX event code that marks the end of a frame
//
// Ports
//   clk, reset    clock and synchronous active-high reset
//   i_enable      1 = capture new frames, 0 = ignore new SFDs
//   i_rx_sfd      SFD-detected level from the RX stage
//   i_rx_active   frame-active level from the RX stage
//   i_ev_sig      one-cycle RX event strobe
//   i_ev          RX event code, valid with i_ev_sig
//   o_ts          SFD timestamp at the FIFO head
//   o_dur         frame duration at the FIFO head
//   o_ts_valid    FIFO non-empty
//   i_ts_ready    consumer pop (takes effect when o_ts_valid & i_ts_ready)
//   o_abort       one-cycle pulse when a frame is dropped without END
//   o_overflow    sticky: a completed frame was lost because the FIFO was full
//   o_time        live free-running counter value
// ---------------------------------------------------------------------------
module rx_sfd_timestamp #(
    parameter int unsigned TS_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [2:0]  RX_EVENT_END = 3'd7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic                i_rx_sfd,
    input  logic                i_rx_active,
    input  logic                i_ev_sig,
    input  logic [2:0]          i_ev,
    output logic [TS_WIDTH-1:0] o_ts,
    output logic [TS_WIDTH-1:0] o_dur,
    output logic                o_ts_valid,
    input  logic                i_ts_ready,
    output logic                o_abort,
    output logic                o_overflow,
    output logic [TS_WIDTH-1:0] o_time
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    // ------------------------------------------------------------------
    // Free-running time counter
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0] counter;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else begin
            counter <= counter + TS_WIDTH'(1);
        end
    end

    assign o_time = counter;

    // ------------------------------------------------------------------
    // SFD rising-edge detection
    // ------------------------------------------------------------------
    logic sfd_prev;
    logic sfd_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            sfd_prev <= 1'b0;
        end else begin
            sfd_prev <= i_rx_sfd;
        end
    end

    assign sfd_rise = i_rx_sfd & ~sfd_prev;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_next;
    logic                start_load;
    logic                push_req;
    logic                abort_set;
    logic                end_event;
    logic [TS_WIDTH-1:0] start_ts;

    assign end_event = i_ev_sig & (i_ev == RX_EVENT_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        push_req   = 1'b0;
        abort_set  = 1'b0;
        case (state)
            IDLE: begin
                if (sfd_rise && i_enable) begin
                    start_load = 1'b1;
                    state_next = FRAME;
                end
            end
            FRAME: begin
                // END wins over a simultaneous loss of rx_active.
                if (end_event) begin
                    push_req   = 1'b1;
                    state_next = IDLE;
                end else if (!i_rx_active) begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_ts <= '0;
            o_abort  <= 1'b0;
        end else begin
            if (start_load) begin
                start_ts <= counter;
            end
            o_abort <= abort_set;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp FIFO
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0] ts_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                fifo_full;
    logic                pop;
    logic                do_push;

    assign o_ts_valid = (count != '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign pop        = o_ts_valid & i_ts_ready;
    // When full, a push is accepted only if the head leaves in the same cycle.
    assign do_push    = push_req & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                ts_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                ts_mem[wr_ptr] <= start_ts;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_req && !do_push) begin
                o_overflow <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_ts = ts_mem[rd_ptr];

`ifdef RX_TS_DURATION_EN
    logic [TS_WIDTH-1:0] dur_mem [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] frame_dur;

    // Modular subtraction keeps the duration correct across counter wrap.
    assign frame_dur = counter - start_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                dur_mem[i] <= '0;
            end
        end else if (do_push) begin
            dur_mem[wr_ptr] <= frame_dur;
        end
    end

    assign o_dur = dur_mem[rd_ptr];
`else
    assign o_dur = '0;
`endif

endmodule

// File: doc/rx_sfd_timestamp.md
RX_SFD_TIMESTAMP -- requirements
Module: rx_sfd_timestamp

Interface
REQ-001 Parameter: TS_WIDTH, default 32, width of the free-running time counter and timestamps.
REQ-002 Parameter: FIFO_DEPTH, default 4, number of timestamp entries; SHALL be a power of two >= 2.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_enable  input  1  1 = capture frames, 0 = ignore new SFDs (frame in progress still completes).
REQ-006 i_rx_sfd  input  1  SFD-detected level from the RX stage.
REQ-007 i_rx_active  input  1  RX frame-active level from the RX stage.
REQ-008 i_ev_sig  input  1  one-cycle RX event strobe.
REQ-009 i_ev  input  3  RX event code, valid when i_ev_sig=1; end code is RX_EVENT_END from rx.vh.
REQ-010 o_ts  output  TS_WIDTH  SFD timestamp at FIFO head.
REQ-011 o_dur  output  TS_WIDTH  frame duration at FIFO head (see Configuration).
REQ-012 o_ts_valid  output  1  FIFO non-empty.
REQ-013 i_ts_ready  input  1  consumer pop; pop occurs when o_ts_valid & i_ts_ready.
REQ-014 o_abort  output  1  one-cycle pulse: frame dropped without END.
REQ-015 o_overflow  output  1  sticky: completed frame lost because FIFO full.
REQ-016 o_time  output  TS_WIDTH  live free-running counter value.

Function
REQ-017 Free-running counter SHALL increment by 1 every clk, wrapping from all-ones to 0; o_time = counter.
REQ-018 SFD rise SHALL be i_rx_sfd=1 while its registered previous value=0.
REQ-019 FSM states: IDLE, FRAME.
REQ-020 IDLE -> FRAME on SFD rise with i_enable=1; counter value of that same cycle SHALL be latched as the start timestamp.
REQ-021 FRAME -> IDLE on i_ev_sig=1 with i_ev=RX_EVENT_END: entry {start timestamp, duration} SHALL be pushed on that edge; o_ts_valid high the next cycle if FIFO was empty.
REQ-022 FRAME -> IDLE on i_rx_active=0 without END in the same cycle: no push, o_abort=1 for exactly one cycle.
REQ-023 END and i_rx_active=0 in the same cycle: treated as END (push, no abort).
REQ-024 Other event codes and further SFD rises in FRAME SHALL be ignored.
REQ-025 Duration = (counter at END − start timestamp) modulo 2^TS_WIDTH, correct across counter wrap.
REQ-026 FIFO full at push without simultaneous pop: entry dropped, o_overflow set to 1, FIFO contents unchanged.
REQ-027 FIFO full with simultaneous pop and push: both SHALL take effect, count stays FIFO_DEPTH.
REQ-028 Pop on empty FIFO SHALL have no effect; o_ts/o_dur SHALL hold head entry contents, 0 when never written.
REQ-029 Deasserting i_enable SHALL NOT flush the FIFO or clear o_overflow.

Reset
REQ-030 On reset: counter=0, FSM=IDLE, FIFO empty, o_ts_valid=0, o_ts=0, o_dur=0, o_abort=0, o_overflow=0, SFD edge register=0.
REQ-031 Reset in FRAME SHALL discard the frame without o_abort pulse.
REQ-032 o_overflow SHALL clear only on reset.

Configuration
REQ-033 Macro RX_TS_DURATION_EN defined: duration computed, stored per entry, driven on o_dur.
REQ-034 Macro RX_TS_DURATION_EN undefined: no duration storage, o_dur tied to 0, all other behaviour identical.

Verification
REQ-035 Reset, enable, SFD rise when o_time=100, END at o_time=350, ready=1 -> o_ts=100, o_dur=250 (0 if macro off), o_ts_valid one cycle.
REQ-036 SFD rise at o_time=0xFFFFFFF0, END at 0x00000010 -> o_ts=0xFFFFFFF0, o_dur=0x20.
REQ-037 SFD rise then i_rx_active=0 with no END -> o_abort one-cycle pulse, o_ts_valid stays 0.
REQ-038 ready=0, five complete frames -> four entries held in order, o_overflow=1; pop four -> o_ts_valid=0, o_overflow still 1.
REQ-039 FIFO full, END coincides with pop -> oldest removed, new entry appended, o_overflow stays 0.
REQ-040 i_enable=0 during SFD rise -> no capture; reset asserted in FRAME -> all outputs 0, no abort pulse.
